// File: rtl/inst_fetch_if.sv
// Fetch-side bundle: instruction memory port, redirect input and decode-stage handshake.
interface inst_fetch_if;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        inst_valid;
    logic [31:0] inst;
    logic [31:0] program_counter;
    logic        inst_ready;

    modport master (
        output imem_req, imem_addr, inst_valid, inst, program_counter,
        input  imem_gnt, imem_rvalid, imem_rdata, redirect, redirect_pc, inst_ready
    );

    modport slave (
        input  imem_req, imem_addr, inst_valid, inst, program_counter,
        output imem_gnt, imem_rvalid, imem_rdata, redirect, redirect_pc, inst_ready
    );
endinterface

// File: rtl/inst_fetch.sv
// Instruction fetch unit: single-outstanding memory requester feeding a small in-order buffer.
// Optional IFETCH_PERF_EN adds a 32-bit count of instructions handed to decode.
module inst_fetch #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter int unsigned BUF_DEPTH = 2
) (
    input  logic        clk,
    input  logic        rstn,
`ifdef IFETCH_PERF_EN
    output logic [31:0] perf_fetched,
`endif
    inst_fetch_if.master bus
);
    localparam int unsigned CW = $clog2(BUF_DEPTH + 1);
    localparam int unsigned AW = $clog2(BUF_DEPTH);

    typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_DISCARD} state_t;

    state_t        r_state;
    state_t        w_state_next;
    logic [31:0]   r_fetch_pc;
    logic [31:0]   r_gnt_pc;
    logic [31:0]   r_buf_inst [BUF_DEPTH];
    logic [31:0]   r_buf_pc   [BUF_DEPTH];
    logic [CW-1:0] r_count;
    logic [CW-1:0] w_count_next;
    logic          r_req;
    logic          r_inst_valid;
    logic          w_pop;
    logic          w_push;
    logic          w_gnt;
    logic [AW-1:0] w_wr_idx;
    logic          w_unused;

    assign w_pop    = r_inst_valid & bus.inst_ready;
    assign w_gnt    = (r_state == S_REQ) & bus.imem_gnt;
    assign w_push   = (r_state == S_WAIT) & bus.imem_rvalid & ~bus.redirect;
    // Head is always entry 0; a new word lands just above the surviving entries.
    assign w_wr_idx = AW'(r_count - CW'(w_pop));
    assign w_unused = ^bus.redirect_pc[1:0];

    // Next state and buffer occupancy
    always_comb begin
        w_state_next = r_state;
        w_count_next = r_count;
        if (bus.redirect) begin
            w_count_next = '0;
            if (((r_state == S_WAIT) && !bus.imem_rvalid) || w_gnt || (r_state == S_DISCARD)) begin
                w_state_next = S_DISCARD;
            end else begin
                w_state_next = S_IDLE;
            end
        end else begin
            w_count_next = r_count + CW'(w_push) - CW'(w_pop);
            unique case (r_state)
                S_IDLE:    if (r_count < CW'(BUF_DEPTH)) w_state_next = S_REQ;
                S_REQ:     if (bus.imem_gnt) w_state_next = S_WAIT;
                S_WAIT:    if (bus.imem_rvalid) w_state_next = S_IDLE;
                S_DISCARD: if (bus.imem_rvalid) w_state_next = S_IDLE;
            endcase
        end
    end

    // State, fetch address and instruction buffer
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state      <= S_IDLE;
            r_fetch_pc   <= RESET_PC;
            r_gnt_pc     <= '0;
            r_count      <= '0;
            r_req        <= 1'b0;
            r_inst_valid <= 1'b0;
            for (int i = 0; i < int'(BUF_DEPTH); i++) begin
                r_buf_inst[AW'(i)] <= '0;
                r_buf_pc[AW'(i)]   <= '0;
            end
        end else begin
            r_state      <= w_state_next;
            r_count      <= w_count_next;
            r_req        <= (w_state_next == S_REQ);
            r_inst_valid <= (w_count_next != '0);
            if (bus.redirect) begin
                r_fetch_pc <= {bus.redirect_pc[31:2], 2'b00};
            end else if (w_gnt) begin
                r_fetch_pc <= r_fetch_pc + 32'd4;
                r_gnt_pc   <= r_fetch_pc;
            end
            if (!bus.redirect) begin
                if (w_pop) begin
                    for (int i = 0; i < int'(BUF_DEPTH) - 1; i++) begin
                        r_buf_inst[AW'(i)] <= r_buf_inst[AW'(i + 1)];
                        r_buf_pc[AW'(i)]   <= r_buf_pc[AW'(i + 1)];
                    end
                end
                if (w_push) begin
                    r_buf_inst[w_wr_idx] <= bus.imem_rdata;
                    r_buf_pc[w_wr_idx]   <= r_gnt_pc;
                end
            end
        end
    end

    assign bus.imem_req        = r_req;
    assign bus.imem_addr       = r_fetch_pc;
    assign bus.inst_valid      = r_inst_valid;
    assign bus.inst            = r_buf_inst[0];
    assign bus.program_counter = r_buf_pc[0];

`ifdef IFETCH_PERF_EN
    logic [31:0] r_perf_fetched;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_perf_fetched <= '0;
        end else if (w_pop) begin
            r_perf_fetched <= r_perf_fetched + 32'd1;
        end
    end

    assign perf_fetched = r_perf_fetched;
`endif

endmodule

// File: tb/tb_inst_fetch.sv
// Bench for inst_fetch: table vectors, directed corner sequences and a randomized
// memory/redirect run checked against an in-order delivered-stream model.
module tb_inst_fetch;
    logic clk = 1'b0;
    logic rstn;
    int   checks   = 0;
    int   failures = 0;

    always #5 clk = ~clk;

    inst_fetch_if b0();
    inst_fetch_if b1();
`ifdef IFETCH_PERF_EN
    logic [31:0] perf0;
    logic [31:0] perf1;
`endif

    inst_fetch #(.RESET_PC(32'h0000_0000), .BUF_DEPTH(2)) dut0 (
        .clk(clk), .rstn(rstn),
`ifdef IFETCH_PERF_EN
        .perf_fetched(perf0),
`endif
        .bus(b0)
    );

    inst_fetch #(.RESET_PC(32'hFFFF_FFF8), .BUF_DEPTH(4)) dut1 (
        .clk(clk), .rstn(rstn),
`ifdef IFETCH_PERF_EN
        .perf_fetched(perf1),
`endif
        .bus(b1)
    );

    typedef struct {
        logic        gnt;
        logic        rvalid;
        logic        ready;
        logic [31:0] rdata;
        logic        exp_req;
        logic [31:0] exp_addr;
        logic        exp_valid;
        logic [31:0] exp_pc;
        logic [31:0] exp_inst;
    } vec_t;

    vec_t vt[13];

    // dut0 reference: next address to fetch, next address to be delivered, memory pending
    logic [31:0] m_fetch;
    logic [31:0] m_exp_pc;
    bit          pend;
    bit          pend_stale;
    int          pend_lat;
    logic [31:0] pend_addr;
    bit          p_hold;
    bit          p_redir;
    logic [31:0] p_pc;
    logic [31:0] p_inst;
    int          pops0;

    bit          pend1;
    logic [31:0] pa1;
    logic [31:0] exp1;
    int          pops1;

    function automatic logic [31:0] memf(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'hC3A5_5A3C;
    endfunction

    function automatic vec_t mkv(input logic g, input logic rv, input logic [31:0] rd,
                                 input logic er, input logic [31:0] ea,
                                 input logic ev, input logic [31:0] epc);
        vec_t v;
        v.gnt = g; v.rvalid = rv; v.ready = 1'b1; v.rdata = rd;
        v.exp_req = er; v.exp_addr = ea; v.exp_valid = ev;
        v.exp_pc = epc; v.exp_inst = memf(epc);
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chk_zero_outputs(input string tag);
        chk({tag, "_req0"},   32'(b0.imem_req), 32'h0);
        chk({tag, "_valid0"}, 32'(b0.inst_valid), 32'h0);
        chk({tag, "_inst0"},  b0.inst, 32'h0);
        chk({tag, "_pc0"},    b0.program_counter, 32'h0);
    endtask

    // One dut0 cycle: check outputs against the model, drive memory/redirect, advance.
    task automatic cyc(input bit rdy, input bit force_redir, input logic [31:0] tgt,
                       input int gnt_pct, input int lat_min, input int lat_max, input int redir_pct);
        bit          rv;
        bit          gn;
        bit          rd;
        logic [31:0] t;
        if (p_redir) begin
            chk("flush_after_redirect", 32'(b0.inst_valid), 32'h0);
        end else if (p_hold) begin
            chk("hold_valid", 32'(b0.inst_valid), 32'h1);
            chk("hold_pc", b0.program_counter, p_pc);
            chk("hold_inst", b0.inst, p_inst);
        end
        if (pend && !pend_stale) chk("one_outstanding", 32'(b0.imem_req), 32'h0);
        if (b0.imem_req) chk("fetch_addr", b0.imem_addr, m_fetch);

        rv = 1'b0;
        if (pend) begin
            pend_lat--;
            if (pend_lat == 0) rv = 1'b1;
        end
        gn = b0.imem_req && !pend && (int'($urandom_range(0, 99)) < gnt_pct);
        rd = force_redir || (!rv && (int'($urandom_range(0, 99)) < redir_pct));
        t  = force_redir ? tgt : $urandom();

        b0.imem_gnt    = gn;
        b0.imem_rvalid = rv;
        b0.imem_rdata  = rv ? memf(pend_addr) : $urandom();
        b0.inst_ready  = rdy;
        b0.redirect    = rd;
        b0.redirect_pc = t;

        if (b0.inst_valid && rdy) begin
            chk("deliver_pc", b0.program_counter, m_exp_pc);
            chk("deliver_inst", b0.inst, memf(m_exp_pc));
            m_exp_pc += 32'd4;
            pops0++;
        end
        if (rv) begin
            pend       = 1'b0;
            pend_stale = 1'b0;
        end
        if (gn) begin
            pend      = 1'b1;
            pend_addr = b0.imem_addr;
            pend_lat  = int'($urandom_range(lat_min, lat_max));
        end
        if (rd) begin
            m_fetch  = {t[31:2], 2'b00};
            m_exp_pc = m_fetch;
        end else if (gn) begin
            m_fetch += 32'd4;
        end
        p_redir = rd;
        p_hold  = b0.inst_valid && !rdy && !rd;
        p_pc    = b0.program_counter;
        p_inst  = b0.inst;
        @(posedge clk); #1;
    endtask

    // One dut1 cycle: grant immediately when enabled, respond next cycle, check deliveries.
    task automatic cyc1(input bit rdy, input bit gnt_en);
        bit rv;
        rv = pend1;
        b1.imem_rvalid = rv;
        b1.imem_rdata  = rv ? memf(pa1) : 32'h0;
        b1.imem_gnt    = gnt_en && b1.imem_req && !pend1;
        b1.inst_ready  = rdy;
        if (b1.inst_valid && rdy) begin
            chk("d4_pc", b1.program_counter, exp1);
            chk("d4_inst", b1.inst, memf(exp1));
            exp1 += 32'd4;
            pops1++;
        end
        if (rv) pend1 = 1'b0;
        if (b1.imem_gnt) begin
            pend1 = 1'b1;
            pa1   = b1.imem_addr;
        end
        @(posedge clk); #1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        bit ok;
        int n;

        rstn = 1'b0;
        b0.imem_gnt = 0; b0.imem_rvalid = 0; b0.imem_rdata = 0; b0.redirect = 0; b0.redirect_pc = 0; b0.inst_ready = 0;
        b1.imem_gnt = 0; b1.imem_rvalid = 0; b1.imem_rdata = 0; b1.redirect = 0; b1.redirect_pc = 0; b1.inst_ready = 0;
        pend = 0; pend_stale = 0; pend_lat = 0; pend_addr = 0; p_hold = 0; p_redir = 0; p_pc = 0; p_inst = 0;
        pops0 = 0; pend1 = 0; pa1 = 0; exp1 = 32'hFFFF_FFF8; pops1 = 0;

        #3;
        chk_zero_outputs("reset");
        chk("reset_d4_req", 32'(b1.imem_req), 32'h0);
        chk("reset_d4_valid", 32'(b1.inst_valid), 32'h0);
        @(posedge clk); @(posedge clk); #2;
        rstn = 1'b1;

        // Back-to-back fetch from 0: gnt with req, rvalid next cycle, ready held high
        vt[0] = mkv(1'b0, 1'b0, 32'h0, 1'b1, 32'h0, 1'b0, 32'h0);
        for (int k = 0; k < 4; k++) begin
            logic [31:0] a;
            a = 32'(4 * k);
            vt[1 + 3 * k] = mkv(1'b1, 1'b0, 32'h0,    1'b0, 32'h0,        1'b0, 32'h0);
            vt[2 + 3 * k] = mkv(1'b0, 1'b1, memf(a),  1'b0, 32'h0,        1'b1, a);
            vt[3 + 3 * k] = mkv(1'b0, 1'b0, 32'h0,    1'b1, a + 32'd4,    1'b0, 32'h0);
        end
        for (int i = 0; i < 13; i++) begin
            b0.imem_gnt    = vt[i].gnt;
            b0.imem_rvalid = vt[i].rvalid;
            b0.imem_rdata  = vt[i].rdata;
            b0.inst_ready  = vt[i].ready;
            @(posedge clk); #1;
            chk($sformatf("vec%0d_req", i), 32'(b0.imem_req), 32'(vt[i].exp_req));
            chk($sformatf("vec%0d_valid", i), 32'(b0.inst_valid), 32'(vt[i].exp_valid));
            if (vt[i].exp_req) chk($sformatf("vec%0d_addr", i), b0.imem_addr, vt[i].exp_addr);
            if (vt[i].exp_valid) begin
                chk($sformatf("vec%0d_pc", i), b0.program_counter, vt[i].exp_pc);
                chk($sformatf("vec%0d_inst", i), b0.inst, vt[i].exp_inst);
            end
            if (i == 0) begin
                chk("d4_first_req", 32'(b1.imem_req), 32'h1);
                chk("d4_first_addr", b1.imem_addr, 32'hFFFF_FFF8);
            end
        end
        m_fetch = 32'd16; m_exp_pc = 32'd16;

        // Stall downstream: buffer fills to depth 2, requests stop, head stays put
        for (int i = 0; i < 10; i++) cyc(1'b0, 1'b0, 32'h0, 100, 1, 1, 0);
        chk("stall_req_low", 32'(b0.imem_req), 32'h0);
        chk("stall_valid", 32'(b0.inst_valid), 32'h1);
        chk("stall_pc", b0.program_counter, 32'd16);
        n = 0;
        for (int i = 0; i < 6; i++) begin
            if (b0.inst_valid) n++;
            cyc(1'b1, 1'b0, 32'h0, 0, 1, 1, 0);
        end
        chk("stall_drain_count", 32'(n), 32'd2);

        // Redirect to 0x103 while waiting on a response
        ok = 0;
        for (int i = 0; i < 10 && !ok; i++) begin
            cyc(1'b1, 1'b0, 32'h0, 100, 2, 2, 0);
            ok = pend && (pend_lat == 2);
        end
        chk("reach_wait", 32'(ok), 32'h1);
        cyc(1'b1, 1'b1, 32'h0000_0103, 100, 2, 2, 0);
        ok = 0;
        for (int i = 0; i < 10; i++) begin
            if (b0.imem_req) begin ok = 1; break; end
            cyc(1'b1, 1'b0, 32'h0, 100, 1, 1, 0);
        end
        chk("redir_req_seen", 32'(ok), 32'h1);
        chk("redir_addr", b0.imem_addr, 32'h0000_0100);
        ok = 0;
        for (int i = 0; i < 10; i++) begin
            if (b0.inst_valid) begin ok = 1; chk("redir_first_pc", b0.program_counter, 32'h100); break; end
            cyc(1'b1, 1'b0, 32'h0, 100, 1, 1, 0);
        end
        chk("redir_delivered", 32'(ok), 32'h1);

        // Redirect coinciding with a push and a pop
        ok = 0;
        for (int i = 0; i < 30 && !ok; i++) begin
            cyc(1'b0, 1'b0, 32'h0, 100, 1, 1, 0);
            ok = b0.inst_valid && pend && (pend_lat == 1);
        end
        chk("reach_push_pop", 32'(ok), 32'h1);
        cyc(1'b1, 1'b1, 32'h0000_0300, 100, 1, 1, 0);
        chk("push_pop_flush", 32'(b0.inst_valid), 32'h0);
        for (int i = 0; i < 10; i++) cyc(1'b1, 1'b0, 32'h0, 100, 1, 1, 0);

        // Reset pulse while a response is in flight
        ok = 0;
        for (int i = 0; i < 30 && !ok; i++) begin
            cyc(1'b0, 1'b0, 32'h0, 100, 2, 2, 0);
            ok = b0.inst_valid && pend && (pend_lat == 2);
        end
        chk("reach_wait_buffered", 32'(ok), 32'h1);
        #2 rstn = 1'b0;
        #1;
        chk_zero_outputs("pulse");
        @(posedge clk); #1;
        chk_zero_outputs("pulse_hold");
        #1 rstn = 1'b1;
        m_fetch = 32'h0; m_exp_pc = 32'h0; pend_stale = pend; p_hold = 0; p_redir = 0; pops0 = 0;
        ok = 0;
        for (int i = 0; i < 12; i++) begin
            if (b0.inst_valid) begin ok = 1; chk("post_reset_pc", b0.program_counter, 32'h0); break; end
            cyc(1'b1, 1'b0, 32'h0, 100, 1, 1, 0);
        end
        chk("post_reset_delivered", 32'(ok), 32'h1);

        // Random memory timing, backpressure and redirects
        n = pops0;
        for (int i = 0; i < 3000; i++) cyc($urandom_range(0, 3) != 0, 1'b0, 32'h0, 60, 1, 3, 3);
        chk("random_progress", 32'(pops0 - n > 200), 32'h1);
        b0.imem_gnt = 0; b0.imem_rvalid = 0; b0.redirect = 0; b0.inst_ready = 0;
        // Let any pending response land so dut0 goes quiet
        for (int i = 0; i < 4 && pend; i++) cyc(1'b0, 1'b0, 32'h0, 0, 1, 1, 0);

        // Depth-4 instance starting near the top of the address space
        for (int i = 0; i < 30 && pops1 < 3; i++) cyc1(1'b1, 1'b1);
        chk("wrap_pops", 32'(pops1), 32'd3);
        for (int i = 0; i < 20; i++) cyc1(1'b0, 1'b1);
        chk("d4_req_low", 32'(b1.imem_req), 32'h0);
        n = 0;
        for (int i = 0; i < 10; i++) begin
            if (b1.inst_valid) n++;
            cyc1(1'b1, 1'b0);
        end
        chk("d4_drain_count", 32'(n), 32'd4);

`ifdef IFETCH_PERF_EN
        chk("perf0", perf0, 32'(pops0));
        chk("perf1", perf1, 32'(pops1));
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
